// File: rtl/aud_cfg_pkg.sv
// rtl/aud_cfg_pkg.sv - shared types, codec address and register table for the audio codec configurator
package aud_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } cfg_state_t;

    localparam logic [7:0] CODEC_ADDR = 8'h34;

    // Entry 0 sits in the least significant slot; each entry is {reg_addr[6:0], reg_val[8:0]}.
    localparam logic [7:0][15:0] CFG_TABLE = {
        16'h0000, 16'h0000, 16'h1201, 16'h0E02,
        16'h0A00, 16'h0812, 16'h0C00, 16'h1E00
    };

    function automatic logic [15:0] cfg_lookup(input logic [2:0] idx);
        return CFG_TABLE[idx];
    endfunction

endpackage

// File: rtl/aud_cfg_seq.sv
// rtl/aud_cfg_seq.sv - walks the codec register table, handing one write at a time to an I2C engine
module aud_cfg_seq
    import aud_cfg_pkg::*;
#(
    parameter int NUM_REGS       = 6,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start_cfg,
    input  logic       i2c_done,
    output logic       i2c_start,
    output logic [7:0] dev_addr,
    output logic [7:0] sec_data,
    output logic [7:0] third_data,
    output logic [2:0] reg_idx,
    output logic       busy,
    output logic       cfg_done,
    output logic       cfg_err
);

    localparam logic [2:0]  LAST_IDX = 3'(NUM_REGS - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST = 16'(SETTLE_CYCLES - 1);

    cfg_state_t  r_state;
    cfg_state_t  w_next;
    logic        r_done_q;
    logic [15:0] r_tmo;
    logic [15:0] r_gap;
    logic [2:0]  r_idx;
    logic [7:0]  r_sec;
    logic [7:0]  r_third;
    logic        r_start;
    logic        r_busy;
    logic        r_cfg_done;
    logic        r_cfg_err;

    logic        w_at_rest;
    logic        w_done_rise;
    logic        w_tmo_hit;
    logic        w_gap_end;
    logic [2:0]  w_idx_nxt;
    logic [15:0] w_entry;
    logic        w_start_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_err_nxt;

    assign w_at_rest   = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR);
    assign w_done_rise = i2c_done && !r_done_q;
    assign w_tmo_hit   = (r_tmo == TMO_LAST);
    assign w_gap_end   = (r_gap == GAP_LAST);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // In WAIT a DONE edge beats a simultaneous timeout terminal count.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: if (start_cfg) w_next = ST_LOAD;
            ST_LOAD:                  w_next = ST_SEND;
            ST_SEND: begin
                if (!i2c_done)      w_next = ST_WAIT;
                else if (w_tmo_hit) w_next = ST_ERR;
            end
            ST_WAIT: begin
                if (w_done_rise)    w_next = ST_GAP;
                else if (w_tmo_hit) w_next = ST_ERR;
            end
            ST_GAP: begin
                if (w_gap_end) w_next = (r_idx == LAST_IDX) ? ST_DONE : ST_LOAD;
            end
            default:                  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_idx_nxt = r_idx;
        if (w_at_rest && start_cfg) begin
            w_idx_nxt = 3'd0;
        end else if ((r_state == ST_GAP) && w_gap_end && (r_idx != LAST_IDX)) begin
            w_idx_nxt = r_idx + 3'd1;
        end
        w_entry     = cfg_lookup(w_idx_nxt);
        w_start_nxt = (w_next == ST_SEND);
        w_busy_nxt  = (w_next == ST_LOAD) || (w_next == ST_SEND) ||
                      (w_next == ST_WAIT) || (w_next == ST_GAP);
        w_done_nxt  = (w_next == ST_DONE);
        w_err_nxt   = (w_next == ST_ERR);
    end

    // Outputs are registered from the next state so i2c_start cannot glitch on a state decode.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_done_q   <= 1'b0;
            r_tmo      <= 16'd0;
            r_gap      <= 16'd0;
            r_idx      <= 3'd0;
            r_sec      <= 8'd0;
            r_third    <= 8'd0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_cfg_done <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_done_q   <= i2c_done;
            r_idx      <= w_idx_nxt;
            r_start    <= w_start_nxt;
            r_busy     <= w_busy_nxt;
            r_cfg_done <= w_done_nxt;
            r_cfg_err  <= w_err_nxt;

            if (w_next == ST_LOAD) begin
                r_sec   <= w_entry[15:8];
                r_third <= w_entry[7:0];
            end

            if (r_state == ST_LOAD) begin
                r_tmo <= 16'd0;
            end else if ((r_state == ST_SEND) || (r_state == ST_WAIT)) begin
                if (r_tmo != 16'hFFFF) r_tmo <= r_tmo + 16'd1;
            end

            if (r_state == ST_GAP) begin
                r_gap <= r_gap + 16'd1;
            end else begin
                r_gap <= 16'd0;
            end
        end
    end

    assign i2c_start  = r_start;
    assign dev_addr   = CODEC_ADDR;
    assign sec_data   = r_sec;
    assign third_data = r_third;
    assign reg_idx    = r_idx;
    assign busy       = r_busy;
    assign cfg_done   = r_cfg_done;
    assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_aud_cfg_seq.sv
// tb/tb_aud_cfg_seq.sv - self-checking bench for aud_cfg_seq with a behavioural I2C engine
module tb_aud_cfg_seq;

    typedef struct {
        logic [2:0] idx;
        logic [7:0] sec;
        logic [7:0] third;
        int         slen;
    } txn_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       start_cfg = 1'b0;
    logic       i2c_done = 1'b0;
    logic       i2c_start;
    logic [7:0] dev_addr;
    logic [7:0] sec_data;
    logic [7:0] third_data;
    logic [2:0] reg_idx;
    logic       busy;
    logic       cfg_done;
    logic       cfg_err;

    txn_t       vecs[6];
    txn_t       exp_q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         ack_delay = 1;
    bit         fail_en = 1'b0;
    logic [2:0] fail_idx = 3'd2;
    int         txn_seen = 0;
    int         busy_cnt = 0;
    int         start_cyc = 0;
    int         end_cyc = 0;

    bit         eng_active = 1'b0;
    bit         cmp_pending = 1'b0;
    int         eng_cnt = 0;
    int         slen = 0;
    logic [2:0] o_idx;
    logic [7:0] o_sec, o_third, o_addr;

    aud_cfg_seq dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .start_cfg (start_cfg),
        .i2c_done  (i2c_done),
        .i2c_start (i2c_start),
        .dev_addr  (dev_addr),
        .sec_data  (sec_data),
        .third_data(third_data),
        .reg_idx   (reg_idx),
        .busy      (busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Engine: latches the write on START, drops a stale DONE ack_delay cycles later, raises DONE 40 cycles after START.
    always @(negedge Clk) begin : eng_model
        txn_t e;
        if (busy) busy_cnt++;
        if (!Reset) begin
            eng_active  = 1'b0;
            cmp_pending = 1'b0;
            i2c_done    = 1'b0;
        end else if (!eng_active && i2c_start) begin
            eng_active  = 1'b1;
            eng_cnt     = 0;
            slen        = 1;
            o_idx       = reg_idx;
            o_sec       = sec_data;
            o_third     = third_data;
            o_addr      = dev_addr;
            start_cyc   = cyc;
            cmp_pending = 1'b1;
            txn_seen++;
        end else if (eng_active) begin
            eng_cnt++;
            if (i2c_start) begin
                slen++;
            end else if (cmp_pending) begin
                cmp_pending = 1'b0;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_txn: idx %0d seen, none expected", o_idx);
                end else begin
                    e = exp_q.pop_front();
                    check("txn_idx", 32'(o_idx), 32'(e.idx));
                    check("txn_sec", 32'(o_sec), 32'(e.sec));
                    check("txn_third", 32'(o_third), 32'(e.third));
                    check("txn_addr", 32'(o_addr), 32'h34);
                    check("txn_start_len", slen, e.slen);
                end
            end
            if (eng_cnt == ack_delay) i2c_done = 1'b0;
            if (eng_cnt == 40 && !(fail_en && o_idx == fail_idx)) begin
                i2c_done   = 1'b1;
                eng_active = 1'b0;
            end
        end
    end

    task automatic push_run(input int n, input bit first_stale);
        for (int i = 0; i < n; i++) begin
            txn_t e;
            e = vecs[i];
            e.slen = (i == 0 && !first_stale) ? 1 : ack_delay + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(negedge Clk);
        start_cfg = 1'b1;
        @(negedge Clk);
        start_cfg = 1'b0;
    endtask

    task automatic wait_run(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (cfg_done || cfg_err) begin
                ok = 1'b1;
                end_cyc = cyc;
                break;
            end
        end
        check("run_terminates", 32'(ok), 32'd1);
    endtask

    task automatic wait_txn(input int target, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge Clk);
            if (txn_seen >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check("txn_reached", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        repeat (5) @(negedge Clk);
    endtask

    task automatic check_run_ok(input string tag);
        check({tag, "_cfg_done"}, 32'(cfg_done), 32'd1);
        check({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_reg_idx"}, 32'(reg_idx), 32'd5);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int base;
        vecs[0] = '{3'd0, 8'h1E, 8'h00, 0};
        vecs[1] = '{3'd1, 8'h0C, 8'h00, 0};
        vecs[2] = '{3'd2, 8'h08, 8'h12, 0};
        vecs[3] = '{3'd3, 8'h0A, 8'h00, 0};
        vecs[4] = '{3'd4, 8'h0E, 8'h02, 0};
        vecs[5] = '{3'd5, 8'h12, 8'h01, 0};

        // Reset state
        repeat (3) @(negedge Clk);
        check("rst_i2c_start", 32'(i2c_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfg_done", 32'(cfg_done), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_reg_idx", 32'(reg_idx), 32'd0);
        check("rst_sec", 32'(sec_data), 32'd0);
        check("rst_third", 32'(third_data), 32'd0);
        check("rst_dev_addr", 32'(dev_addr), 32'h34);
        Reset = 1'b1;
        repeat (8) @(negedge Clk);
        check("idle_hold_busy", 32'(busy), 32'd0);
        check("idle_hold_start", 32'(i2c_start), 32'd0);

        // Run 1: fresh engine, one cycle acknowledge; 6 x (1 + 41 + 16) busy cycles
        ack_delay = 1;
        busy_cnt = 0;
        pulse_start();
        push_run(6, 1'b0);
        wait_run(2000);
        check_run_ok("run1");
        check("run1_latency", busy_cnt, 348);

        // Run 2 from DONE with DONE still high: START must be held until the engine drops DONE
        ack_delay = 5;
        busy_cnt = 0;
        pulse_start();
        push_run(6, 1'b1);
        wait_run(2000);
        check_run_ok("run2");
        check("run2_latency", busy_cnt, 348);

        // Run 3: start_cfg pulsed during GAP of entry 1 must not queue a second run
        ack_delay = 1;
        base = txn_seen;
        pulse_start();
        push_run(6, 1'b1);
        wait_txn(base + 2, 500);
        repeat (44) @(negedge Clk);
        check("gap_busy", 32'(busy), 32'd1);
        check("gap_start_low", 32'(i2c_start), 32'd0);
        pulse_start();
        wait_run(2000);
        check_run_ok("run3");
        repeat (100) @(negedge Clk);
        check("run3_txn_count", txn_seen - base, 6);
        check("run3_still_done", 32'(cfg_done), 32'd1);

        // Timeout on entry 2
        fail_en = 1'b1;
        pulse_start();
        push_run(3, 1'b1);
        wait_run(6000);
        check("tmo_cfg_err", 32'(cfg_err), 32'd1);
        check("tmo_cfg_done", 32'(cfg_done), 32'd0);
        check("tmo_reg_idx", 32'(reg_idx), 32'd2);
        check("tmo_i2c_start", 32'(i2c_start), 32'd0);
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_latency", end_cyc - start_cyc, 4096);
        check("tmo_queue_empty", exp_q.size(), 0);
        fail_en = 1'b0;
        do_reset();

        // Reset asserted during WAIT of entry 3, then a clean restart from entry 0
        base = txn_seen;
        pulse_start();
        push_run(6, 1'b0);
        wait_txn(base + 4, 1000);
        repeat (10) @(negedge Clk);
        check("pre_rst_start_low", 32'(i2c_start), 32'd0);
        Reset = 1'b0;
        #1;
        check("arst_i2c_start", 32'(i2c_start), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_reg_idx", 32'(reg_idx), 32'd0);
        check("arst_sec", 32'(sec_data), 32'd0);
        check("arst_third", 32'(third_data), 32'd0);
        check("arst_cfg_done", 32'(cfg_done), 32'd0);
        check("arst_pending", exp_q.size(), 2);
        exp_q.delete();
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        repeat (20) @(negedge Clk);
        check("post_rst_idle", 32'(busy), 32'd0);
        check("post_rst_no_txn", txn_seen - base, 4);
        busy_cnt = 0;
        pulse_start();
        push_run(6, 1'b0);
        wait_run(2000);
        check_run_ok("run4");
        check("run4_latency", busy_cnt, 348);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
